// File: rtl/serv_rf_ram_arb.sv
// rtl/serv_rf_ram_arb.sv - RF-priority SRAM arbiter that slots host word accesses into idle RAM cycles
module serv_rf_ram_arb #(
    parameter int width = 8,
    parameter int aw    = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [aw-1:0]    i_rf_waddr,
    input  logic [width-1:0] i_rf_wdata,
    input  logic             i_rf_wen,
    input  logic [aw-1:0]    i_rf_raddr,
    input  logic             i_rf_ren,
    output logic [width-1:0] o_rf_rdata,
    input  logic             i_h_valid,
    output logic             o_h_ready,
    input  logic             i_h_we,
    input  logic [aw-1:0]    i_h_addr,
    input  logic [width-1:0] i_h_wdata,
    output logic             o_h_rvalid,
    input  logic             i_h_rready,
    output logic [width-1:0] o_h_rdata,
    output logic [aw-1:0]    o_waddr,
    output logic [width-1:0] o_wdata,
    output logic             o_wen,
    output logic [aw-1:0]    o_raddr,
    output logic             o_ren,
    input  logic [width-1:0] i_rdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_ISSUED = 2'd1,
        RD_HOLD   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             ren_d;
    logic             h_rvalid_next;
    logic [width-1:0] h_rdata_next;
    logic             hwg;
    logic             hrg;

    // The RF side samples i_rdata one and two cycles after its strobe, so a
    // host read must avoid both the strobe cycle and the one after it.
    assign o_h_ready = i_rst_n & (state == IDLE) &
                       (i_h_we ? !i_rf_wen : (!i_rf_ren & !ren_d));

    assign hwg = i_h_valid & o_h_ready & i_h_we;
    assign hrg = i_h_valid & o_h_ready & !i_h_we;

    assign o_wen   = i_rf_wen | hwg;
    assign o_waddr = hwg ? i_h_addr : i_rf_waddr;
    assign o_wdata = hwg ? i_h_wdata : i_rf_wdata;

    assign o_ren   = i_rf_ren | hrg;
    assign o_raddr = hrg ? i_h_addr : i_rf_raddr;

    assign o_rf_rdata = i_rdata;

    always_comb begin
        state_next    = state;
        h_rvalid_next = o_h_rvalid;
        h_rdata_next  = o_h_rdata;
        case (state)
            IDLE: begin
                if (hrg) begin
                    state_next = RD_ISSUED;
                end
            end
            RD_ISSUED: begin
                state_next    = RD_HOLD;
                h_rdata_next  = i_rdata;
                h_rvalid_next = 1'b1;
            end
            RD_HOLD: begin
                if (i_h_rready) begin
                    state_next    = IDLE;
                    h_rvalid_next = 1'b0;
                end
            end
            default: begin
                state_next    = IDLE;
                h_rvalid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            ren_d      <= 1'b0;
            o_h_rvalid <= 1'b0;
            o_h_rdata  <= '0;
        end else begin
            state      <= state_next;
            ren_d      <= i_rf_ren;
            o_h_rvalid <= h_rvalid_next;
            o_h_rdata  <= h_rdata_next;
        end
    end

endmodule

// File: tb/tb_serv_rf_ram_arb.sv
// tb/tb_serv_rf_ram_arb.sv - self-checking bench for serv_rf_ram_arb with SRAM and shadow-memory model
module tb_serv_rf_ram_arb;

    localparam int W  = 8;
    localparam int AW = 6;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] rf_waddr;
    logic [W-1:0]  rf_wdata;
    logic          rf_wen;
    logic [AW-1:0] rf_raddr;
    logic          rf_ren;
    logic [W-1:0]  rf_rdata;
    logic          h_valid;
    logic          h_ready;
    logic          h_we;
    logic [AW-1:0] h_addr;
    logic [W-1:0]  h_wdata;
    logic          h_rvalid;
    logic          h_rready;
    logic [W-1:0]  h_rdata;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic          wen;
    logic [AW-1:0] raddr;
    logic          ren;
    logic [W-1:0]  rdata;

    logic [W-1:0]  mem [0:(1<<AW)-1];
    logic [W-1:0]  shadow [0:(1<<AW)-1];

    int tests;
    int fails;

    serv_rf_ram_arb #(.width(W), .aw(AW)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rf_waddr (rf_waddr),
        .i_rf_wdata (rf_wdata),
        .i_rf_wen   (rf_wen),
        .i_rf_raddr (rf_raddr),
        .i_rf_ren   (rf_ren),
        .o_rf_rdata (rf_rdata),
        .i_h_valid  (h_valid),
        .o_h_ready  (h_ready),
        .i_h_we     (h_we),
        .i_h_addr   (h_addr),
        .i_h_wdata  (h_wdata),
        .o_h_rvalid (h_rvalid),
        .i_h_rready (h_rready),
        .o_h_rdata  (h_rdata),
        .o_waddr    (waddr),
        .o_wdata    (wdata),
        .o_wen      (wen),
        .o_raddr    (raddr),
        .o_ren      (ren),
        .i_rdata    (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: read-before-write, output held while ren is low.
    always @(posedge clk) begin
        if (wen) mem[waddr] <= wdata;
        if (ren) rdata <= mem[raddr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        rf_wen = 0; rf_ren = 0; h_valid = 0; h_we = 0; h_rready = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        idle_inputs();
        rf_wen = 1; rf_waddr = AW'($urandom); rf_wdata = W'($urandom);
        h_valid = 1; h_we = 1; h_addr = AW'($urandom); h_wdata = W'($urandom);
        #1;
        tests++; if (h_rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid got %b want 0", h_rvalid); end
        tests++; if (h_rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata got %h want 00", h_rdata); end
        tests++; if (h_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", h_ready); end
        tests++; if (wen !== 1'b1 || waddr !== rf_waddr || wdata !== rf_wdata) begin
            fails++; $display("FAIL reset_wport got %b/%h/%h want 1/%h/%h", wen, waddr, wdata, rf_waddr, rf_wdata);
        end
        repeat (3) @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1;
        tick();
        tick();
    endtask

    task automatic test_host_write_read;
        logic [W-1:0] d;
        d = 8'hA5;
        tick();
        h_valid = 1; h_we = 1; h_addr = 6'h05; h_wdata = d;
        #1;
        tests++; if (h_ready !== 1'b1 || wen !== 1'b1 || waddr !== 6'h05 || wdata !== d) begin
            fails++; $display("FAIL hw_grant got rdy=%b wen=%b a=%h d=%h want 1 1 05 %h", h_ready, wen, waddr, wdata, d);
        end
        tick();
        h_we = 0;
        #1;
        tests++; if (h_ready !== 1'b1 || ren !== 1'b1 || raddr !== 6'h05 || wen !== 1'b0) begin
            fails++; $display("FAIL hr_grant got rdy=%b ren=%b a=%h wen=%b want 1 1 05 0", h_ready, ren, raddr, wen);
        end
        tick();
        h_valid = 0;
        #1;
        tests++; if (h_rvalid !== 1'b0 || h_ready !== 1'b0) begin
            fails++; $display("FAIL hr_issued got rvalid=%b rdy=%b want 0 0", h_rvalid, h_ready);
        end
        tick();
        #1;
        tests++; if (h_rvalid !== 1'b1 || h_rdata !== d) begin
            fails++; $display("FAIL hr_data got rvalid=%b data=%h want 1 %h", h_rvalid, h_rdata, d);
        end
        h_rready = 1;
        tick();
        h_rready = 0;
        #1;
        tests++; if (h_rvalid !== 1'b0 || h_ready !== 1'b1) begin
            fails++; $display("FAIL hr_release got rvalid=%b rdy=%b want 0 1", h_rvalid, h_ready);
        end
    endtask

    task automatic test_rf_write_blocks(input logic [W-1:0] hd);
        logic [AW-1:0] ra;
        logic [W-1:0]  rd;
        ra = 6'h30; rd = W'($urandom);
        tick();
        rf_wen = 1; rf_waddr = ra; rf_wdata = rd;
        h_valid = 1; h_we = 1; h_addr = 6'h12; h_wdata = hd;
        #1;
        tests++; if (h_ready !== 1'b0 || wen !== 1'b1 || waddr !== ra || wdata !== rd) begin
            fails++; $display("FAIL rfw_block got rdy=%b wen=%b a=%h d=%h want 0 1 %h %h", h_ready, wen, waddr, wdata, ra, rd);
        end
        tick();
        rf_wen = 0;
        #1;
        tests++; if (h_ready !== 1'b1 || wen !== 1'b1 || waddr !== 6'h12 || wdata !== hd) begin
            fails++; $display("FAIL rfw_release got rdy=%b wen=%b a=%h d=%h want 1 1 12 %h", h_ready, wen, waddr, wdata, hd);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_read_slot(input logic [W-1:0] hd);
        tick();
        rf_ren = 1; rf_raddr = 6'h05;
        h_valid = 1; h_we = 0; h_addr = 6'h12;
        #1;
        tests++; if (h_ready !== 1'b0 || ren !== 1'b1 || raddr !== 6'h05) begin
            fails++; $display("FAIL slot_ren got rdy=%b ren=%b a=%h want 0 1 05", h_ready, ren, raddr);
        end
        tick();
        rf_ren = 0;
        #1;
        tests++; if (h_ready !== 1'b0 || ren !== 1'b0 || rf_rdata !== 8'hA5) begin
            fails++; $display("FAIL slot_rend got rdy=%b ren=%b rf=%h want 0 0 a5", h_ready, ren, rf_rdata);
        end
        tick();
        #1;
        tests++; if (h_ready !== 1'b1 || ren !== 1'b1 || raddr !== 6'h12 || rf_rdata !== 8'hA5) begin
            fails++; $display("FAIL slot_grant got rdy=%b ren=%b a=%h rf=%h want 1 1 12 a5", h_ready, ren, raddr, rf_rdata);
        end
        tick();
        h_valid = 0;
        tick();
        #1;
        tests++; if (h_rvalid !== 1'b1 || h_rdata !== hd) begin
            fails++; $display("FAIL slot_data got rvalid=%b data=%h want 1 %h", h_rvalid, h_rdata, hd);
        end
        h_rready = 1;
        tick();
        h_rready = 0;
    endtask

    task automatic test_write_during_rf_read;
        logic [W-1:0] d;
        d = W'($urandom);
        tick();
        rf_ren = 1; rf_raddr = 6'h05;
        h_valid = 1; h_we = 1; h_addr = 6'h20; h_wdata = d;
        #1;
        tests++; if (h_ready !== 1'b1 || wen !== 1'b1 || waddr !== 6'h20 || wdata !== d || ren !== 1'b1 || raddr !== 6'h05) begin
            fails++; $display("FAIL wr_rfread got rdy=%b wen=%b wa=%h ren=%b ra=%h want 1 1 20 1 05", h_ready, wen, waddr, ren, raddr);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_read_hold;
        tick();
        h_valid = 1; h_we = 0; h_addr = 6'h05;
        tick();
        h_valid = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            h_valid = 1; h_we = 1'($urandom); h_addr = AW'($urandom); h_wdata = W'($urandom);
            #1;
            tests++; if (h_rvalid !== 1'b1 || h_rdata !== 8'hA5 || h_ready !== 1'b0) begin
                fails++; $display("FAIL hold_%0d got rvalid=%b data=%h rdy=%b want 1 a5 0", i, h_rvalid, h_rdata, h_ready);
            end
        end
        tick();
        h_valid = 0; h_we = 0; h_rready = 1;
        tick();
        h_rready = 0;
        #1;
        tests++; if (h_rvalid !== 1'b0 || h_ready !== 1'b1) begin
            fails++; $display("FAIL hold_release got rvalid=%b rdy=%b want 0 1", h_rvalid, h_ready);
        end
    endtask

    task automatic test_reset_mid_read;
        tick();
        h_valid = 1; h_we = 0; h_addr = 6'h05;
        tick();
        h_valid = 0;
        tick();
        tick();
        #2;
        rst_n = 0;
        #1;
        tests++; if (h_rvalid !== 1'b0) begin fails++; $display("FAIL rst_mid_rvalid got %b want 0", h_rvalid); end
        tick();
        rst_n = 1;
        tick();
        h_valid = 1; h_we = 0; h_addr = 6'h20;
        #1;
        tests++; if (h_ready !== 1'b1 || ren !== 1'b1) begin
            fails++; $display("FAIL rst_fresh_grant got rdy=%b ren=%b want 1 1", h_ready, ren);
        end
        tick();
        h_valid = 0;
        tick();
        #1;
        tests++; if (h_rvalid !== 1'b1 || h_rdata !== mem[6'h20]) begin
            fails++; $display("FAIL rst_fresh_data got rvalid=%b data=%h want 1 %h", h_rvalid, h_rdata, mem[6'h20]);
        end
        h_rready = 1;
        tick();
        h_rready = 0;
    endtask

    // Random traffic against a transaction-level model: shadow memory, one
    // outstanding host read, and the RF sampling window after each RF read.
    task automatic test_random;
        int           phase;
        logic [W-1:0] exp_hd;
        logic         prev_ren;
        logic         req;
        logic         exp_ready;
        logic         grant;
        logic         e1v, e2v;
        logic [W-1:0] e1, e2;
        int           errs;
        errs = 0;
        for (int a = 0; a < (1 << AW); a++) begin
            tick();
            idle_inputs();
            rf_wen = 1; rf_waddr = AW'(a); rf_wdata = W'($urandom);
            shadow[a] = rf_wdata;
        end
        tick();
        idle_inputs();
        phase = 0; exp_hd = '0; prev_ren = 0; req = 0; e1v = 0; e2v = 0; e1 = '0; e2 = '0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            rf_wen = ($urandom_range(0, 2) == 0);
            rf_waddr = AW'($urandom); rf_wdata = W'($urandom);
            rf_ren = ($urandom_range(0, 2) == 0);
            rf_raddr = AW'($urandom);
            if (!req && $urandom_range(0, 1) == 1) begin
                req = 1; h_we = 1'($urandom); h_addr = AW'($urandom); h_wdata = W'($urandom);
            end
            h_valid = req;
            h_rready = (phase == 2) && ($urandom_range(0, 2) == 0);
            #1;
            exp_ready = (phase == 0) && (h_we ? !rf_wen : (!rf_ren && !prev_ren));
            grant = req && exp_ready;
            tests++; if (h_ready !== exp_ready) begin
                fails++; errs++; $display("FAIL rnd_ready c=%0d got %b want %b", c, h_ready, exp_ready);
            end
            tests++; if (wen !== (rf_wen || (grant && h_we)) ||
                         (grant && h_we && (waddr !== h_addr || wdata !== h_wdata)) ||
                         (rf_wen && (waddr !== rf_waddr || wdata !== rf_wdata))) begin
                fails++; errs++; $display("FAIL rnd_wport c=%0d got %b/%h/%h", c, wen, waddr, wdata);
            end
            tests++; if (ren !== (rf_ren || (grant && !h_we)) ||
                         (grant && !h_we && raddr !== h_addr) ||
                         (rf_ren && raddr !== rf_raddr)) begin
                fails++; errs++; $display("FAIL rnd_rport c=%0d got %b/%h", c, ren, raddr);
            end
            tests++; if (h_rvalid !== (phase == 2) || (phase == 2 && h_rdata !== exp_hd)) begin
                fails++; errs++; $display("FAIL rnd_hdata c=%0d got %b/%h want %b/%h", c, h_rvalid, h_rdata, phase == 2, exp_hd);
            end
            if (e1v) begin
                tests++; if (rf_rdata !== e1) begin fails++; errs++; $display("FAIL rnd_rf1 c=%0d got %h want %h", c, rf_rdata, e1); end
            end
            if (e2v) begin
                tests++; if (rf_rdata !== e2) begin fails++; errs++; $display("FAIL rnd_rf2 c=%0d got %h want %h", c, rf_rdata, e2); end
            end
            e2v = e1v && !rf_ren; e2 = e1;
            e1v = rf_ren; e1 = shadow[rf_raddr];
            if (phase == 2 && h_rready) phase = 0;
            else if (phase == 1) phase = 2;
            if (grant && !h_we) begin exp_hd = shadow[h_addr]; phase = 1; end
            if (rf_wen) shadow[rf_waddr] = rf_wdata;
            if (grant && h_we) shadow[h_addr] = h_wdata;
            if (grant) req = 0;
            prev_ren = rf_ren;
            if (errs > 20) break;
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        logic [W-1:0] hd;
        tests = 0;
        fails = 0;
        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        rdata = '0;
        rf_waddr = '0; rf_wdata = '0; rf_raddr = '0; h_addr = '0; h_wdata = '0;
        hd = W'($urandom);
        test_reset();
        test_host_write_read();
        test_rf_write_blocks(hd);
        test_read_slot(hd);
        test_write_during_rf_read();
        test_read_hold();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serv_rf_ram_arb.md
Name: serv_rf_ram_arb

Overview:
- Sits directly downstream of the register-file RAM interface, between its RAM-side port and the SRAM macro.
- Passes the RF interface's read and write strobes through combinationally with absolute priority. The RF interface has fixed timing and can never be stalled.
- Slots word-wide accesses from a host/debug port (valid/ready) into idle RAM cycles. Used for register preload, FPU state dump and debugger register access.
- Host read data is captured and held until the host consumes it.

Parameters:
- width, 8, SRAM data width; must match the RF interface width.
- aw, 6, SRAM address width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_rf_waddr  in  aw  RF-side write address
- i_rf_wdata  in  width  RF-side write data
- i_rf_wen  in  1  RF-side write strobe
- i_rf_raddr  in  aw  RF-side read address
- i_rf_ren  in  1  RF-side read strobe
- o_rf_rdata  out  width  read data to RF side; equals i_rdata, combinational
- i_h_valid  in  1  host request valid
- o_h_ready  out  1  host request accepted this cycle when high with i_h_valid
- i_h_we  in  1  1 = write, 0 = read
- i_h_addr  in  aw  host word address
- i_h_wdata  in  width  host write data
- o_h_rvalid  out  1  host read data valid
- i_h_rready  in  1  host consumes read data
- o_h_rdata  out  width  host read data, registered
- o_waddr  out  aw  SRAM write address
- o_wdata  out  width  SRAM write data
- o_wen  out  1  SRAM write enable
- o_raddr  out  aw  SRAM read address
- o_ren  out  1  SRAM read enable
- i_rdata  in  width  SRAM read data; valid the cycle after o_ren and held while o_ren is low

Behaviour:
- Reset, asynchronous while i_rst_n=0:
  - state=IDLE, ren_d=0.
  - o_h_rvalid=0, o_h_rdata=0.
  - o_wen/o_ren follow RF inputs only; host grants are 0.
- ren_d is a register holding i_rf_ren from the previous cycle.
- Read-slot rule: the RF side samples i_rdata one and two cycles after its ren. A host read at cycle t is therefore legal only if i_rf_ren(t)=0 and ren_d(t)=0.
- Write-slot rule: a host write at t is legal only if i_rf_wen(t)=0.
- o_h_ready = (state==IDLE) & (i_h_we ? !i_rf_wen : (!i_rf_ren & !ren_d)). It is combinational; no dependence on i_h_valid.
- Write grant (hwg = i_h_valid & o_h_ready & i_h_we):
  - o_wen=1, o_waddr=i_h_addr, o_wdata=i_h_wdata.
  - Otherwise the write port carries the RF inputs.
- Read grant (hrg = i_h_valid & o_h_ready & !i_h_we):
  - o_ren=1, o_raddr=i_h_addr.
  - Otherwise the read port carries the RF inputs.
- Host writes and RF reads may coexist in one cycle, and host reads and RF writes may too; the ports are independent.
- State machine:
  - IDLE -> RD_ISSUED on hrg. Writes complete in the grant cycle; state stays IDLE.
  - RD_ISSUED -> RD_HOLD unconditionally: o_h_rdata <= i_rdata, o_h_rvalid <= 1.
  - RD_HOLD: o_h_rdata and o_h_rvalid held. On i_h_rready, o_h_rvalid <= 0 and state <= IDLE.
- Read latency: data visible on o_h_rvalid exactly 2 cycles after the grant edge.
- Only one host read is outstanding; o_h_ready=0 in RD_ISSUED and RD_HOLD for reads and writes alike.
- RF ren asserted while in RD_ISSUED: RAM output changes next cycle, but capture already happened this cycle from the host read. The read-slot rule guarantees the RF side's sample is not corrupted.
- Host request not granted: request must remain stable until o_h_ready. Starvation is bounded by the RF transaction length; no timeout.
- Reset mid-read: outstanding read is discarded and o_h_rvalid drops immediately.
- Same-address host write and RF read in one cycle: RAM read-during-write semantics apply; the arbiter does no forwarding.

Test Plan:
- Idle RF, host write addr 0x05 data 0xA5 -> o_wen=1, o_waddr=0x05 that cycle. Host read 0x05 -> o_h_rvalid=1 with 0xA5 two cycles after grant.
- RF write active (i_rf_wen=1) with host write pending -> o_h_ready=0, RAM gets RF data. The cycle i_rf_wen drops, the host write is granted.
- Host read requested in the cycle after i_rf_ren=1 -> o_h_ready=0. Granted one cycle later; RF side sees unchanged i_rdata on both sample cycles.
- Host write during RF read burst -> granted immediately, o_wen=1 while o_ren=1 from RF with RF address.
- Read data held: i_h_rready=0 for 5 cycles -> o_h_rvalid=1 and o_h_rdata stable, o_h_ready=0 throughout. i_h_rready=1 -> next cycle o_h_rvalid=0, IDLE.
- Assert i_rst_n=0 in RD_HOLD -> o_h_rvalid=0 asynchronously. After release, a fresh host read completes normally.
